imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and packs each group of 4 bytes, MSB first, into a 32-bit word. It writes the words into instruction memory starting at the core's reset PC, and holds the core's PC update until the load completes. It is the write side of the instruction memory; the core's fetch path is the read side.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width (depth = 2^ADDR_W words).
- `BASE_WORD`, default 40: word index of the first word written; matches the core's reset PC of byte address 160.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: single-cycle pulse; begins a load when the FSM is in IDLE.
- `word_count` in ADDR_W+1: number of words to load; sampled on the accepted `start`.
- `rx_data` in 8: program byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out 32: byte address of the write, equal to (BASE_WORD + word index) << 2.
- `imem_wdata` out 32: assembled word.
- `cpu_hold` out 1: high while loading; the core gates its PC register with it.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse when a load finishes.
- `err` out 1: sticky range error; cleared by the next accepted `start` or by reset.

## Operation
- **States:** IDLE, RECV, WRITE, DONE. State and all outputs are registered.
- **IDLE:**
  - On `start`, if `word_count` == 0, go to DONE; no writes occur.
  - On `start`, if BASE_WORD + `word_count` > 2^ADDR_W, set `err` and stay in IDLE; no writes occur.
  - Otherwise latch `word_count`, clear `word_idx` and `byte_cnt`, clear `err`, and go to RECV.
- **RECV:**
  - `rx_ready` = 1.
  - On `rx_valid` && `rx_ready`, shift the assembly register: asm = {asm[23:0], rx_data}, and increment `byte_cnt` (2 bits).
  - On the 4th accepted byte (`byte_cnt` == 3), go to WRITE.
- **WRITE:**
  - `rx_ready` = 0, `imem_we` = 1, `imem_wdata` = asm, `imem_addr` = (BASE_WORD + `word_idx`) << 2.
  - Increment `word_idx`.
  - If `word_idx` == latched count − 1, go to DONE; otherwise go to RECV.
- **DONE:** `done` = 1 for one cycle, `cpu_hold` drops, then go to IDLE.
- `cpu_hold` = 1 in RECV and WRITE, and 0 in IDLE and DONE.
- `start` is ignored in every state except IDLE.
- Bytes offered while `rx_ready` = 0 are not consumed; the sender holds them.
- Address arithmetic is done in ADDR_W+1 bits, then zero-extended and shifted into 32 bits. The range check guarantees the address never wraps.

## Timing
- **Reset values:** state = IDLE; `rx_ready`, `imem_we`, `cpu_hold`, `busy`, `done`, `err` = 0; `imem_addr`, `imem_wdata`, the assembly register and all counters = 0.
- **Reset mid-load:** the FSM aborts immediately. Words already written stay in memory; the partially assembled word is discarded.
- **Start to first byte:** RECV is entered the cycle after the `start` edge, so the first byte can be accepted 1 cycle after `start`.
- **Write latency:** `imem_we` is asserted in the cycle immediately after the 4th-byte handshake.
- **Throughput:** one word per 5 cycles when `rx_valid` is held high (4 accept cycles plus 1 write bubble).
- **Total load time:** last `imem_we` is followed 1 cycle later by `done`. Minimum total = 1 + 5·N cycles from `start` to the `done` cycle.
- **`start` with `word_count` = 0:** `done` pulses 1 cycle after `start`, with no `cpu_hold`.
- **Out-of-range `start`:** `err` is high in the cycle after `start`; `busy` stays 0.

## Structure
- **Shared package `mips_pkg`:**
  - state enum {IDLE, RECV, WRITE, DONE}
  - `IMEM_BASE_WORD` = 40
  - `WORD_BYTES` = 4
- **Sub-module `byte_packer`:** the natural split. It holds the shift register plus the 2-bit `byte_cnt` and outputs `word_ready` on the 4th byte. It is cleared by the FSM on `start`.
- The FSM, address counter and range check stay in `imem_loader`.

## Test plan
- **Single word:** `word_count` = 1, bytes 0x20,0x08,0x00,0x05 back-to-back → one `imem_we` with `imem_addr` = 0xA0 and `imem_wdata` = 0x20080005; `done` the next cycle; `cpu_hold` high for exactly 5 cycles.
- **Three words with `rx_valid` gaps:** → writes at 0xA0, 0xA4, 0xA8 with correct data. `rx_ready` is 0 in each WRITE cycle, and no byte is lost or duplicated.
- **Zero count:** `word_count` = 0 → `done` 1 cycle after `start`; no `imem_we`; `cpu_hold` never high.
- **Range error:** `ADDR_W` = 8, `word_count` = 217 → `err` = 1; `busy` = 0; no writes. A following valid `start` clears `err`.
- **Reset mid-load:** pull `rst_n` low after the 2nd byte of word 1 → all outputs 0 asynchronously. After release, a fresh load of 1 word writes 0xA0 correctly.
- **`start` while busy:** pulse `start` during RECV → ignored; `word_count` is not re-sampled and the load completes unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's boot-time instruction-memory loader.
// Holds the loader state encoding and the core's reset-PC word index.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  localparam int unsigned IMEM_BASE_WORD = 40;
  localparam int unsigned WORD_BYTES     = 4;

  // Instruction memory is word-organised; the core addresses it in bytes.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_index);
    return word_index << 2;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// The last byte of a word is merged combinationally, so word_next is complete on the 4th handshake.
module byte_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  output logic [31:0] word_next,
  output logic        word_ready
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [23:0] asm_q, asm_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_comb begin
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    word_next  = {asm_q, rx_data};
    word_ready = 1'b0;
    if (clear) begin
      asm_d      = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      asm_d      = {asm_q[15:0], rx_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_ready = (byte_cnt_q == LAST_BYTE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      byte_cnt_q <= '0;
    end else begin
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: receives a program byte stream and writes
// packed words from the core's reset PC upward while holding the core's PC.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_WORD = IMEM_BASE_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   BASE_W = (ADDR_W+1)'(BASE_WORD);
  localparam logic [ADDR_W:0]   ONE_W  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W+1:0] DEPTH  = (ADDR_W+2)'(1) << ADDR_W;

  loader_state_e state_q, state_d;

  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] word_idx_q, word_idx_d;
  logic            err_q, err_d;
  logic [31:0]     imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            rx_ready_q, rx_ready_d;
  logic            imem_we_q, imem_we_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            packer_clear;
  logic            packer_accept;
  logic [31:0]     word_next;
  logic            word_ready;
  logic [ADDR_W+1:0] end_word;
  logic            range_bad;
  logic [ADDR_W:0] word_sum;

  // Wider than the address so a full-depth load is distinguishable from overflow.
  assign end_word  = (ADDR_W+2)'(BASE_WORD) + (ADDR_W+2)'(word_count);
  assign range_bad = (end_word > DEPTH);
  assign word_sum  = BASE_W + word_idx_q;

  assign packer_accept = rx_valid && rx_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (packer_clear),
    .accept     (packer_accept),
    .rx_data    (rx_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    err_d        = err_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    packer_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            count_d      = word_count;
            word_idx_d   = '0;
            err_d        = 1'b0;
            packer_clear = 1'b1;
            state_d      = RECV;
          end
        end
      end
      RECV: begin
        if (word_ready) begin
          imem_wdata_d = word_next;
          imem_addr_d  = word_to_byte_addr(32'(word_sum));
          state_d      = WRITE;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + ONE_W;
        state_d    = (word_idx_q == count_q - ONE_W) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the registered state.
    rx_ready_d = (state_d == RECV);
    imem_we_d  = (state_d == WRITE);
    cpu_hold_d = (state_d == RECV) || (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      err_q        <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      err_q        <= err_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a write-list model plus timing rules
// derived from the 5-cycles-per-word handshake, with a few literal pins.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int BASE   = 40;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        gap_en = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_WORD(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model: word i of a load goes to byte address (BASE+i)*4 with its bytes packed MSB first.
  task automatic queueWords(input logic [31:0] words[$]);
    for (int i = 0; i < words.size(); i++) begin
      exp_addr_q.push_back((BASE + i) * 4);
      exp_data_q.push_back(words[i]);
      for (int b = 3; b >= 0; b--) tx_q.push_back(words[i][8*b +: 8]);
    end
  endtask

  task automatic applyStimulus(input int wc);
    @(negedge clk);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic observe(input int budget, input int restart_off,
                         output int done_off, output int hold_n, output int we_n, output int first_we);
    done_off = -1;
    hold_n   = 0;
    we_n     = 0;
    first_we = -1;
    for (int off = 0; off < budget; off++) begin
      if (off == restart_off) begin
        start      = 1'b1;
        word_count = (ADDR_W+1)'(5);
      end else begin
        start = 1'b0;
      end
      if (cpu_hold) hold_n++;
      if (imem_we) begin
        we_n++;
        if (first_we < 0) first_we = off;
      end
      if (done) begin
        done_off = off;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Byte sender: offers the head of tx_q, popping it when the DUT is ready.
  initial begin
    int tick;
    tick     = 0;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(negedge clk);
      tick++;
      if (tx_q.size() > 0 && !(gap_en && (tick % 3 == 0))) begin
        rx_valid = 1'b1;
        rx_data  = tx_q[0];
        if (rx_ready) void'(tx_q.pop_front());
      end else begin
        rx_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every write and the handshake invariants.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (exp_addr_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_we: got write addr 0x%08h data 0x%08h, expected no write", imem_addr, imem_wdata);
        end else begin
          checkOutput("we_addr", imem_addr, exp_addr_q.pop_front());
          checkOutput("we_data", imem_wdata, exp_data_q.pop_front());
          checkOutput("ready_in_write", 32'(rx_ready), 32'd0);
        end
        last_addr = imem_addr;
        last_data = imem_wdata;
      end
      if (done) checkOutput("hold_at_done", 32'(cpu_hold), 32'd0);
      if (cpu_hold) checkOutput("busy_with_hold", 32'(busy), 32'd1);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_imem_addr"}, imem_addr, 32'd0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    int done_off, hold_n, we_n, first_we;
    logic [31:0] w[$];

    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, back-to-back bytes.
    w = '{32'h20080005};
    queueWords(w);
    applyStimulus(1);
    observe(40, -1, done_off, hold_n, we_n, first_we);
    checkOutput("t1_first_we_off", 32'(first_we), 32'd4);
    checkOutput("t1_done_off", 32'(done_off), 32'(5 * 1));
    checkOutput("t1_hold_cycles", 32'(hold_n), 32'(5 * 1));
    checkOutput("t1_we_count", 32'(we_n), 32'd1);
    checkOutput("t1_addr_literal", last_addr, 32'h0000_00A0);
    checkOutput("t1_data_literal", last_data, 32'h2008_0005);
    @(negedge clk);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);

    // Three words with gaps in rx_valid.
    gap_en = 1'b1;
    w = '{32'h8C090004, 32'h01095020, 32'hAC0A0008};
    queueWords(w);
    applyStimulus(3);
    observe(100, -1, done_off, hold_n, we_n, first_we);
    gap_en = 1'b0;
    checkOutput("t2_we_count", 32'(we_n), 32'd3);
    checkOutput("t2_done_slower", 32'(done_off >= 15), 32'd1);
    checkOutput("t2_bytes_left", 32'(tx_q.size()), 32'd0);
    checkOutput("t2_last_addr_literal", last_addr, 32'h0000_00A8);
    checkOutput("t2_last_data_literal", last_data, 32'hAC0A_0008);

    // Zero count.
    repeat (2) @(negedge clk);
    applyStimulus(0);
    observe(10, -1, done_off, hold_n, we_n, first_we);
    checkOutput("t3_done_off", 32'(done_off), 32'd0);
    checkOutput("t3_hold_cycles", 32'(hold_n), 32'd0);
    checkOutput("t3_we_count", 32'(we_n), 32'd0);

    // Range error: 40 + 217 exceeds 256 words.
    repeat (2) @(negedge clk);
    applyStimulus(217);
    checkOutput("t4_err_set", 32'(err), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    observe(6, -1, done_off, hold_n, we_n, first_we);
    checkOutput("t4_no_done", done_off, 32'hFFFF_FFFF);
    checkOutput("t4_we_count", 32'(we_n), 32'd0);
    checkOutput("t4_err_sticky", 32'(err), 32'd1);

    // 40 + 216 fills memory exactly: accepted, clears err. Reset after 2 bytes of word 1.
    w = '{32'h3C011001};
    queueWords(w);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    applyStimulus(216);
    checkOutput("t5_err_cleared", 32'(err), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 50 && tx_q.size() > 0; i++) @(negedge clk);
    checkOutput("t5_bytes_sent", 32'(tx_q.size()), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetState("midload");
    tx_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{32'hDEADBEEF};
    queueWords(w);
    applyStimulus(1);
    observe(40, -1, done_off, hold_n, we_n, first_we);
    checkOutput("t5_reload_done_off", 32'(done_off), 32'd5);
    checkOutput("t5_reload_addr_literal", last_addr, 32'h0000_00A0);
    checkOutput("t5_reload_data_literal", last_data, 32'hDEAD_BEEF);

    // start during RECV must be ignored.
    repeat (2) @(negedge clk);
    w = '{32'h00000001, 32'h00000002};
    queueWords(w);
    applyStimulus(2);
    observe(60, 2, done_off, hold_n, we_n, first_we);
    word_count = '0;
    checkOutput("t6_we_count", 32'(we_n), 32'd2);
    checkOutput("t6_done_off", 32'(done_off), 32'(5 * 2));
    checkOutput("t6_hold_cycles", 32'(hold_n), 32'(5 * 2));
    repeat (3) @(negedge clk);
    checkOutput("t6_idle_after", 32'(busy), 32'd0);
    checkOutput("all_writes_seen", 32'(exp_addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
